// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_pkg
// Brief    : Shared EX-stage types and constants for the 5-bit-FS RISC pipe.
// Revision : 1.0
// ============================================================================
package risc_pkg;

    localparam logic [1:0] BS_INC  = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_RAA  = 2'b10;
    localparam logic [1:0] BS_BRA  = 2'b11;

    localparam logic [4:0] FS_MOVA = 5'b00000;
    localparam logic [4:0] FS_INC  = 5'b00001;
    localparam logic [4:0] FS_ADD  = 5'b00010;
    localparam logic [4:0] FS_SUB  = 5'b00101;
    localparam logic [4:0] FS_DEC  = 5'b00110;
    localparam logic [4:0] FS_AND  = 5'b01000;
    localparam logic [4:0] FS_OR   = 5'b01010;
    localparam logic [4:0] FS_XOR  = 5'b01100;
    localparam logic [4:0] FS_NOT  = 5'b01110;
    localparam logic [4:0] FS_MOVB = 5'b10000;
    localparam logic [4:0] FS_LSR  = 5'b10100;
    localparam logic [4:0] FS_LSL  = 5'b11000;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ex_state_t;

    // One decoded instruction as carried across DOF->EX and EX->WB.
    typedef struct packed {
        logic        rw;
        logic [4:0]  da;
        logic [1:0]  md;
        logic [1:0]  bs;
        logic        ps;
        logic        mw;
        logic [4:0]  fs;
        logic [4:0]  sh;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [31:0] pc;
    } ex_fields_t;

endpackage
`default_nettype wire

// File: rtl/risc_ex_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : risc_ex_issue_ctrl_if
// Brief    : Valid/ready pipeline-stage handshake carrying one decoded beat.
// Revision : 1.0
// ============================================================================
interface risc_ex_issue_ctrl_if;
    import risc_pkg::*;

    logic       valid;
    logic       ready;
    ex_fields_t data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/risc_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : risc_branch_resolve
// Brief    : Combinational BS/PS branch decision and redirect-target select.
// Revision : 1.0
// ============================================================================
module risc_branch_resolve
    import risc_pkg::*;
(
    input  wire logic [1:0]  bs,
    input  wire logic        ps,
    input  wire logic        z,
    input  wire logic [31:0] bra,
    input  wire logic [31:0] raa,
    output logic             taken,
    output logic [31:0]      target
);

    always_comb begin
        taken  = 1'b0;
        target = bra;
        case (bs)
            BS_INC:  taken = 1'b0;
            // PS=0 branches on zero, PS=1 on nonzero
            BS_COND: taken = (z == !ps);
            BS_RAA: begin
                taken  = 1'b1;
                target = raa;
            end
            BS_BRA:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/risc_ex_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : risc_ex_issue_ctrl
// Brief    : EX-stage issue register, branch resolution and wrong-path flush.
// Revision : 1.0
// ============================================================================
module risc_ex_issue_ctrl
    import risc_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    risc_ex_issue_ctrl_if.slave   dof,
    risc_ex_issue_ctrl_if.master  ex,
    input  wire logic             EX_WB_Z,
    input  wire logic [31:0]      EX_WB_BrA,
    input  wire logic [31:0]      EX_WB_RAA,
    output logic                  branch_taken,
    output logic [31:0]           pc_target,
    output logic                  flush,
    output logic [CNT_W-1:0]      retire_cnt,
    output logic [CNT_W-1:0]      squash_cnt
);

    localparam logic [2:0]       c_FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    ex_state_t        r_state;
    logic [2:0]       r_flush_ctr;
    logic             r_ex_valid;
    ex_fields_t       r_ex_data;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    logic             w_xfer;
    logic             w_dof_ready;
    logic             w_accept;
    logic             w_res_taken;
    logic [31:0]      w_res_target;
    logic             w_taken;
    logic             w_flush;

    risc_branch_resolve u_branch_resolve (
        .bs     (r_ex_data.bs),
        .ps     (r_ex_data.ps),
        .z      (EX_WB_Z),
        .bra    (EX_WB_BrA),
        .raa    (EX_WB_RAA),
        .taken  (w_res_taken),
        .target (w_res_target)
    );

    assign w_xfer      = r_ex_valid & ex.ready;
    assign w_dof_ready = !r_ex_valid | ex.ready;
    assign w_accept    = dof.valid & w_dof_ready;
    // A branch only counts once it actually leaves EX for WB.
    assign w_taken     = w_xfer & w_res_taken;
    assign w_flush     = (r_state == FLUSH) | w_taken;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= RUN;
            r_flush_ctr <= 3'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_taken) begin
                        r_state     <= FLUSH;
                        r_flush_ctr <= c_FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    r_flush_ctr <= r_flush_ctr - 3'd1;
                    if (r_flush_ctr <= 3'd1) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_flush_ctr <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex_valid   <= 1'b0;
            r_ex_data    <= '0;
            r_retire_cnt <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_retire_cnt <= r_retire_cnt + c_CNT_ONE;
            end
            if (w_accept && w_flush) begin
                r_ex_valid   <= 1'b0;
                r_squash_cnt <= r_squash_cnt + c_CNT_ONE;
            end else if (w_accept) begin
                r_ex_valid <= 1'b1;
                r_ex_data  <= dof.data;
            end else if (w_xfer) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign dof.ready    = w_dof_ready;
    assign ex.valid     = r_ex_valid;
    assign ex.data      = r_ex_data;
    assign branch_taken = w_taken;
    assign pc_target    = w_taken ? w_res_target : 32'd0;
    assign flush        = w_flush;
    assign retire_cnt   = r_retire_cnt;
    assign squash_cnt   = r_squash_cnt;

endmodule
`default_nettype wire

// File: tb/tb_risc_ex_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_ex_issue_ctrl
// Brief    : Directed plus random bench with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_risc_ex_issue_ctrl;
    import risc_pkg::*;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MOD      = 1 << CNT_W;

    logic             clk;
    logic             reset;
    logic             z;
    logic [31:0]      bra;
    logic [31:0]      raa;
    logic             branch_taken;
    logic [31:0]      pc_target;
    logic             flush;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] squash_cnt;

    risc_ex_issue_ctrl_if dof_if ();
    risc_ex_issue_ctrl_if ex_if ();

    risc_ex_issue_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dof          (dof_if.slave),
        .ex           (ex_if.master),
        .EX_WB_Z      (z),
        .EX_WB_BrA    (bra),
        .EX_WB_RAA    (raa),
        .branch_taken (branch_taken),
        .pc_target    (pc_target),
        .flush        (flush),
        .retire_cnt   (retire_cnt),
        .squash_cnt   (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Reference state: the live EX instruction, counters, and how many more
    // cycles the squash window stays open after the branch cycle.
    bit         m_valid;
    ex_fields_t m_data;
    int         m_retire;
    int         m_squash;
    int         m_flush_left;

    function automatic bit rule_taken(input logic [1:0] bs, input logic ps, input logic zf);
        if (bs == 2'b00) return 1'b0;
        if (bs == 2'b01) return (zf == !ps);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit          e_xfer;
        bit          e_taken;
        logic [31:0] e_target;
        e_xfer   = m_valid && ex_if.ready;
        e_taken  = e_xfer && rule_taken(m_data.bs, m_data.ps, z);
        e_target = e_taken ? ((m_data.bs == 2'b10) ? raa : bra) : 32'd0;
        chk("ex_valid", 128'(ex_if.valid), 128'(m_valid));
        chk("ex_data", 128'(ex_if.data), 128'(m_data));
        chk("dof_ready", 128'(dof_if.ready), 128'(!m_valid || ex_if.ready));
        chk("branch_taken", 128'(branch_taken), 128'(e_taken));
        chk("pc_target", 128'(pc_target), 128'(e_target));
        chk("flush", 128'(flush), 128'((m_flush_left > 0) || e_taken));
        chk("retire_cnt", 128'(retire_cnt), 128'(m_retire));
        chk("squash_cnt", 128'(squash_cnt), 128'(m_squash));
    endtask

    task automatic model_step();
        bit xfer, acc, tk, fl;
        if (!reset) begin
            m_valid = 0; m_data = '0; m_retire = 0; m_squash = 0; m_flush_left = 0;
            return;
        end
        xfer = m_valid && ex_if.ready;
        acc  = dof_if.valid && (!m_valid || ex_if.ready);
        tk   = xfer && rule_taken(m_data.bs, m_data.ps, z);
        fl   = (m_flush_left > 0) || tk;
        if (xfer) m_retire = (m_retire + 1) % CNT_MOD;
        if (acc && fl) begin
            m_valid  = 0;
            m_squash = (m_squash + 1) % CNT_MOD;
        end else if (acc) begin
            m_valid = 1;
            m_data  = dof_if.data;
        end else if (xfer) begin
            m_valid = 0;
        end
        if (tk) m_flush_left = FLUSH_CYCLES;
        else if (m_flush_left > 0) m_flush_left--;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 4
    // units later, well clear of either edge.
    task automatic settle();
        #3;
        if (chk_en) check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_beat(input bit v, input logic [1:0] bs, input logic ps, input logic [31:0] pc);
        dof_if.valid      = v;
        dof_if.data.rw    = 1'($urandom);
        dof_if.data.da    = 5'($urandom);
        dof_if.data.md    = 2'($urandom);
        dof_if.data.bs    = bs;
        dof_if.data.ps    = ps;
        dof_if.data.mw    = 1'($urandom);
        dof_if.data.fs    = FS_ADD;
        dof_if.data.sh    = 5'($urandom);
        dof_if.data.bus_a = 32'd5;
        dof_if.data.bus_b = 32'd7;
        dof_if.data.pc    = pc;
    endtask

    initial begin
        reset = 1'b0; z = 1'b0; bra = '0; raa = '0; ex_if.ready = 1'b1;
        set_beat(1'b1, 2'b00, 1'b0, 32'hDEAD_0000);
        #1;
        // Reset held for two edges with a beat offered
        settle(); tick();
        chk_en = 1;
        settle(); tick();
        chk("rst_ex_valid", 128'(ex_if.valid), 128'(0));
        chk("rst_ex_data", 128'(ex_if.data), 128'(0));
        chk("rst_dof_ready", 128'(dof_if.ready), 128'(1));
        chk("rst_retire", 128'(retire_cnt), 128'(0));
        chk("rst_flush", 128'(flush), 128'(0));
        reset = 1'b1;

        // Streaming: three back-to-back beats, one cycle latency each
        for (int i = 0; i < 3; i++) begin
            set_beat(1'b1, 2'b00, 1'b0, 32'h100 + 32'(4 * i));
            settle(); tick();
            chk("stream_valid", 128'(ex_if.valid), 128'(1));
            chk("stream_pc", 128'(ex_if.data.pc), 128'(32'h100 + 32'(4 * i)));
        end
        dof_if.valid = 1'b0;
        settle(); tick();
        chk("stream_retire", 128'(retire_cnt), 128'(3));

        // Stall: EX held, DOF beat must wait
        set_beat(1'b1, 2'b00, 1'b0, 32'h200);
        settle(); tick();
        set_beat(1'b1, 2'b00, 1'b0, 32'h204);
        ex_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_dof_ready", 128'(dof_if.ready), 128'(0));
            tick();
            chk("stall_pc", 128'(ex_if.data.pc), 128'(32'h200));
            chk("stall_retire", 128'(retire_cnt), 128'(3));
        end
        ex_if.ready = 1'b1;
        settle(); tick();
        chk("stall_release_pc", 128'(ex_if.data.pc), 128'(32'h204));
        dof_if.valid = 1'b0;
        settle(); tick();

        // Conditional branch taken on Z=1, three wrong-path beats squashed
        set_beat(1'b1, 2'b01, 1'b0, 32'h300);
        settle(); tick();
        z = 1'b1; bra = 32'h40; raa = 32'h77;
        set_beat(1'b1, 2'b00, 1'b0, 32'h304);
        settle();
        chk("cond_taken", 128'(branch_taken), 128'(1));
        chk("cond_target", 128'(pc_target), 128'(32'h40));
        tick();
        for (int i = 0; i < 2; i++) begin
            set_beat(1'b1, 2'b00, 1'b0, 32'h308 + 32'(4 * i));
            settle();
            chk("cond_flush", 128'(flush), 128'(1));
            tick();
        end
        chk("cond_squash", 128'(squash_cnt), 128'(3));
        set_beat(1'b1, 2'b00, 1'b0, 32'h310);
        settle(); tick();
        chk("cond_issue_pc", 128'(ex_if.data.pc), 128'(32'h310));
        chk("cond_issue_valid", 128'(ex_if.valid), 128'(1));
        dof_if.valid = 1'b0;
        settle(); tick();

        // Same branch with Z=0: falls through, nothing squashed
        set_beat(1'b1, 2'b01, 1'b0, 32'h400);
        settle(); tick();
        z = 1'b0;
        set_beat(1'b1, 2'b00, 1'b0, 32'h404);
        settle();
        chk("nt_taken", 128'(branch_taken), 128'(0));
        tick();
        chk("nt_squash", 128'(squash_cnt), 128'(3));
        chk("nt_pc", 128'(ex_if.data.pc), 128'(32'h404));
        dof_if.valid = 1'b0;
        settle(); tick();

        // Register jump
        set_beat(1'b1, 2'b10, 1'b0, 32'h500);
        settle(); tick();
        dof_if.valid = 1'b0; raa = 32'h1234; bra = 32'h9999;
        settle();
        chk("raa_target", 128'(pc_target), 128'(32'h1234));
        tick();
        settle(); tick();
        settle(); tick();

        // Unconditional BrA jump, then reset in the second flush cycle
        set_beat(1'b1, 2'b11, 1'b1, 32'h600);
        settle(); tick();
        dof_if.valid = 1'b0; z = 1'b1; bra = 32'h8000;
        settle();
        chk("bra_taken", 128'(branch_taken), 128'(1));
        chk("bra_target", 128'(pc_target), 128'(32'h8000));
        tick();
        settle(); tick();
        reset = 1'b0;
        settle(); tick();
        reset = 1'b1;
        settle();
        chk("rst_mid_flush", 128'(flush), 128'(0));
        tick();

        // Counter wrap: 17 retires on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            set_beat(1'b1, 2'b00, 1'b0, 32'h1000 + 32'(i));
            settle(); tick();
        end
        dof_if.valid = 1'b0;
        settle(); tick();
        chk("wrap_retire", 128'(retire_cnt), 128'(1));

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 63) != 0);
            ex_if.ready   = ($urandom_range(0, 3) != 0);
            z             = 1'($urandom);
            bra           = $urandom;
            raa           = $urandom;
            dof_if.valid  = 1'($urandom);
            dof_if.data   = {$urandom, $urandom, $urandom, $urandom};
            settle(); tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc_ex_issue_ctrl.md
# risc_ex_issue_ctrl

Issue and branch-resolution controller for the EX stage of the 5-bit-FS RISC pipeline. It owns the DOF→EX pipeline register and runs a valid/ready handshake on both sides. It resolves BS/PS branches using the EX stage's Z flag, branch address and register-jump address, and squashes wrong-path instructions for a fixed flush window. It sits between the DOF stage and the combinational EX datapath and feeds WB.

## Interface
- FLUSH_CYCLES, 2: cycles after a taken branch during which accepted DOF beats are discarded (1..7).
- CNT_W, 32: width of the retire and squash counters.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- dof_valid  in  1  DOF beat present
- dof_ready  out  1  controller accepts DOF beat this cycle
- DOF_EX_RW, DOF_EX_DA[4:0], DOF_EX_MD[1:0], DOF_EX_BS[1:0], DOF_EX_PS, DOF_EX_MW, DOF_EX_FS[4:0], DOF_EX_SH[4:0]  in  various  decoded control fields
- DOF_EX_Bus_A, DOF_EX_Bus_B, DOF_EX_PC  in  32 each  operands and PC
- EX_WB_RW … EX_WB_PC  out  same widths  registered EX fields driven into the EX datapath
- ex_valid  out  1  EX register holds a live instruction
- wb_ready  in  1  WB accepts the EX instruction
- EX_WB_Z  in  1  zero flag from the EX datapath (combinational, same cycle)
- EX_WB_BrA, EX_WB_RAA  in  32 each  branch target and register-jump target from the EX datapath
- branch_taken  out  1  combinational; a taken branch retires this cycle
- pc_target  out  32  redirect PC; valid when branch_taken=1, else 0
- flush  out  1  high while in FLUSH or when branch_taken=1; IF/DOF discard their contents
- retire_cnt, squash_cnt  out  CNT_W each  instructions retired to WB / DOF beats discarded

## Operation
- **Transfer:** a beat transfers EX→WB when ex_valid & wb_ready. dof_ready = !ex_valid | wb_ready.
- **Acceptance:** a DOF beat is accepted when dof_valid & dof_ready.
- **Accept in RUN:** if no branch is taken that cycle, the EX register loads all DOF fields and ex_valid←1.
- **Accept when dropped:** if accepted while flush=1, the beat is dropped, ex_valid←0 and squash_cnt increments.
- **Transfer with no accept:** ex_valid←0.
- **Stall:** ex_valid & !wb_ready holds the EX register and all fields unchanged.
- **Branch decision**, only on an EX→WB transfer:
  - BS=00: not taken.
  - BS=01: taken when Z==!PS (PS=0 branches on zero, PS=1 on nonzero); target EX_WB_BrA.
  - BS=10: always taken; target EX_WB_RAA.
  - BS=11: always taken; target EX_WB_BrA.
- **FSM RUN:** a taken branch sets branch_taken=1, drops any DOF beat accepted the same cycle, loads flush_ctr←FLUSH_CYCLES and moves to FLUSH.
- **FSM FLUSH:** dof_ready=1 whenever the EX register is empty or transferring. Each cycle flush_ctr decrements; on reaching 0 the FSM returns to RUN in the next cycle. A branch cannot retire in FLUSH because ex_valid=0.
- **Counters:** retire_cnt increments on every EX→WB transfer. Both counters wrap modulo 2^CNT_W.

## Timing
- **Latency:** DOF beat accepted at cycle t appears on EX_WB_* with ex_valid=1 at t+1.
- branch_taken, pc_target and the leading edge of flush are combinational in the retire cycle.
- **Flush window:** flush stays high for FLUSH_CYCLES further cycles. Total squash window is FLUSH_CYCLES+1 cycles.
- **Reset values**, applied when reset=0 at a clk edge:
  - FSM = RUN, ex_valid = 0, flush_ctr = 0, retire_cnt = 0, squash_cnt = 0.
  - All EX_WB_* field registers = 0.
  - Combinational outputs evaluate to branch_taken=0, pc_target=0, flush=0, dof_ready=1.
- **Reset mid-FLUSH:** the window is abandoned and the FSM is in RUN the next cycle.
- **Simultaneous non-branch retire and accept:** the register reloads with no bubble, giving throughput 1/cycle.
- **dof_valid during stall:** the beat is not accepted; DOF must hold it.

## Structure
- **Shared package `risc_pkg`:**
  - BS encodings BS_INC=2'b00, BS_COND=2'b01, BS_RAA=2'b10, BS_BRA=2'b11.
  - FSM state type {RUN, FLUSH}.
  - The FS opcode constants already used by the EX datapath.
- **Sub-module `risc_branch_resolve`:** combinational; inputs BS, PS, Z, BrA, RAA; outputs taken and target. Instantiated once.

## Test plan
- **Reset:** hold reset=0 two cycles with dof_valid=1 → ex_valid=0, all EX_WB_*=0, counters=0, dof_ready=1.
- **Streaming:** FS=00010, Bus_A=5, Bus_B=7, wb_ready=1, three back-to-back beats → each appears one cycle later; retire_cnt=3; no bubbles.
- **Stall:** wb_ready=0 for 3 cycles with ex_valid=1 → EX_WB_* stable, dof_ready=0, retire_cnt unchanged; releases on wb_ready=1.
- **Conditional branch:**
  - BS=01, PS=0, Z=1, BrA=0x40 → branch_taken=1, pc_target=0x40; next 3 DOF beats dropped with FLUSH_CYCLES=2; squash_cnt=3; 4th beat issues.
  - Repeat with Z=0 → not taken, no squash.
- **Jump variants:**
  - BS=10, RAA=0x1234 → pc_target=0x1234.
  - BS=11, PS=1, Z=1 → taken regardless of Z, target = BrA.
- **Reset and wrap:** assert reset in the second flush cycle → RUN and flush=0 the cycle after release. With CNT_W=4, 17 retires → retire_cnt=1.
